// File: rtl/alu_seq.sv
// alu_seq: LC-3 style execute stage with a multi-cycle shift-add multiply.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start, aluk        operation request (accepted in IDLE only) and opcode
//   sr1_in, sr2_in     operands A and B from the register file
//   imm5, sr2mux_sel   immediate and B-source select (1 = sign-extended imm5)
//   gate_alu           drive result onto alu_bus
//   bus_in, ld_cc      global bus value and NZP load enable
//   busy               multiply in progress
//   done               one-cycle pulse when result updates
//   result             registered result
//   alu_bus            gated result (zero when not gated)
//   nzp                condition codes {N,Z,P}
module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  aluk,
    input  logic [15:0] sr1_in,
    input  logic [15:0] sr2_in,
    input  logic [4:0]  imm5,
    input  logic        sr2mux_sel,
    input  logic        gate_alu,
    input  logic [15:0] bus_in,
    input  logic        ld_cc,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] alu_bus,
    output logic [2:0]  nzp
);

    typedef enum logic {IDLE, MUL} state_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_AND   = 3'b001,
        OP_NOT   = 3'b010,
        OP_PASSA = 3'b011,
        OP_MUL   = 3'b100
    } op_t;

    state_t      state, state_next;
    logic [15:0] op_b;
    logic [15:0] single_res;
    logic [15:0] mcand, mplier, acc, acc_step;
    logic [4:0]  count;
    logic [15:0] result_r;
    logic        done_r;
    logic [2:0]  nzp_r;
    logic        accept, accept_mul, mul_last;

    // B operand after the sr2mux
    assign op_b = sr2mux_sel ? {{11{imm5[4]}}, imm5} : sr2_in;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_mul) state_next = MUL;
            MUL:     if (mul_last)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy       = (state == MUL);
        accept     = (state == IDLE) && start;
        accept_mul = accept && (aluk == OP_MUL);
        mul_last   = (state == MUL) && (count == 5'd15);
    end

    // Single-cycle operations; 101-111 fall through to PASSA
    always_comb begin
        single_res = sr1_in;
        case (aluk)
            OP_ADD:   single_res = sr1_in + op_b;
            OP_AND:   single_res = sr1_in & op_b;
            OP_NOT:   single_res = ~sr1_in;
            OP_PASSA: single_res = sr1_in;
            default:  single_res = sr1_in;
        endcase
    end

    assign acc_step = mplier[0] ? acc + mcand : acc;

    // Datapath: operand capture, shift-add iteration, result and done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_mul) begin
                mcand  <= sr1_in;
                mplier <= op_b;
                acc    <= '0;
                count  <= '0;
            end else if (accept) begin
                result_r <= single_res;
                done_r   <= 1'b1;
            end else if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 5'd1;
                // 16th step: the accumulated sum including this step is final
                if (mul_last) begin
                    result_r <= acc_step;
                    done_r   <= 1'b1;
                end
            end
        end
    end

    // Condition codes, independent of the state machine
    always_ff @(posedge clk) begin
        if (!rst_n)
            nzp_r <= 3'b010;
        else if (ld_cc) begin
            if (bus_in[15])
                nzp_r <= 3'b100;
            else if (bus_in == 16'h0000)
                nzp_r <= 3'b010;
            else
                nzp_r <= 3'b001;
        end
    end

    assign result  = result_r;
    assign done    = done_r;
    assign nzp     = nzp_r;
    assign alu_bus = gate_alu ? result_r : '0;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  aluk;
    logic [15:0] sr1_in, sr2_in;
    logic [4:0]  imm5;
    logic        sr2mux_sel;
    logic        gate_alu;
    logic [15:0] bus_in;
    logic        ld_cc;
    logic        busy, done;
    logic [15:0] result, alu_bus;
    logic [2:0]  nzp;

    int errors = 0;
    int checks = 0;

    alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .aluk       (aluk),
        .sr1_in     (sr1_in),
        .sr2_in     (sr2_in),
        .imm5       (imm5),
        .sr2mux_sel (sr2mux_sel),
        .gate_alu   (gate_alu),
        .bus_in     (bus_in),
        .ld_cc      (ld_cc),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_bus    (alu_bus),
        .nzp        (nzp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  aluk;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  imm;
        logic        sel;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample point inside a cycle: 1 time unit after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cc(input logic [15:0] v, input logic [2:0] exp);
        bus_in = v;
        ld_cc  = 1'b1;
        tick();
        ld_cc  = 1'b0;
        chk("nzp", {13'd0, nzp}, {13'd0, exp});
    endtask

    // Multiply with optional ignored start at T5 and optional ld_cc at T3
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [4:0] imm,
                           input logic sel, input logic [15:0] exp,
                           input logic poke_t5, input logic cc_t3);
        logic [15:0] prev;
        prev       = result;
        aluk       = 3'b100;
        sr1_in     = a;
        sr2_in     = b;
        imm5       = imm;
        sr2mux_sel = sel;
        start      = 1'b1;
        tick();                         // now in T1
        start      = 1'b0;
        sr1_in     = 16'hDEAD;          // operands must already be captured
        sr2_in     = 16'hBEEF;
        imm5       = 5'b01010;
        for (int t = 1; t <= 16; t++) begin
            chk("mul_busy_done", {14'd0, busy, done}, 16'h0002);
            chk("mul_result_hold", result, prev);
            if (poke_t5 && t == 5) begin
                aluk  = 3'b000;
                start = 1'b1;
            end
            if (cc_t3 && t == 3) begin
                bus_in = 16'h8000;
                ld_cc  = 1'b1;
            end
            tick();
            start = 1'b0;
            if (cc_t3 && t == 3) begin
                ld_cc = 1'b0;
                chk("nzp_during_mul", {13'd0, nzp}, 16'h0004);
            end
        end
        // T17
        chk("mul_end_busy_done", {14'd0, busy, done}, 16'h0001);
        chk("mul_result", result, exp);
        tick();
        chk("mul_done_drop", {15'd0, done}, 16'h0000);
        chk("mul_result_held", result, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; aluk = 3'b000; sr1_in = '0; sr2_in = '0;
        imm5 = '0; sr2mux_sel = 1'b0; gate_alu = 1'b0; bus_in = '0; ld_cc = 1'b0;

        vecs[0] = '{3'b000, 16'h0005, 16'h0000, 5'b11111, 1'b1, 16'h0004};
        vecs[1] = '{3'b000, 16'h7FFF, 16'h0001, 5'b00000, 1'b0, 16'h8000};
        vecs[2] = '{3'b000, 16'hFFFF, 16'h0001, 5'b00000, 1'b0, 16'h0000};
        vecs[3] = '{3'b000, 16'h0010, 16'h9999, 5'b01111, 1'b1, 16'h001F};
        vecs[4] = '{3'b001, 16'hF0F0, 16'h3C3C, 5'b00000, 1'b0, 16'h3030};
        vecs[5] = '{3'b001, 16'hFFFF, 16'h0000, 5'b10000, 1'b1, 16'hFFF0};
        vecs[6] = '{3'b011, 16'h1234, 16'h5555, 5'b00000, 1'b0, 16'h1234};
        vecs[7] = '{3'b101, 16'hABCD, 16'h1111, 5'b00000, 1'b0, 16'hABCD};
        vecs[8] = '{3'b111, 16'h0F0F, 16'h2222, 5'b00000, 1'b0, 16'h0F0F};
        vecs[9] = '{3'b010, 16'h00FF, 16'h0000, 5'b00000, 1'b0, 16'hFF00};

        // Reset
        tick();
        tick();
        chk("rst_busy_done", {14'd0, busy, done}, 16'h0000);
        chk("rst_result", result, 16'h0000);
        chk("rst_nzp", {13'd0, nzp}, 16'h0002);
        chk("rst_bus_g0", alu_bus, 16'h0000);
        gate_alu = 1'b1;
        #1;
        chk("rst_bus_g1", alu_bus, 16'h0000);
        gate_alu = 1'b0;
        rst_n = 1'b1;

        // Back-to-back single-cycle ops from the table
        @(negedge clk);
        foreach (vecs[i]) begin
            aluk       = vecs[i].aluk;
            sr1_in     = vecs[i].a;
            sr2_in     = vecs[i].b;
            imm5       = vecs[i].imm;
            sr2mux_sel = vecs[i].sel;
            start      = 1'b1;
            tick();
            chk($sformatf("vec%0d_done", i), {15'd0, done}, 16'h0001);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
        end
        start  = 1'b0;
        sr1_in = 16'h0001;
        tick();
        chk("idle_done_low", {15'd0, done}, 16'h0000);
        chk("idle_result_hold", result, 16'hFF00);
        gate_alu = 1'b1;
        #1;
        chk("bus_gated_on", alu_bus, 16'hFF00);
        gate_alu = 1'b0;
        #1;
        chk("bus_gated_off", alu_bus, 16'h0000);

        // Condition codes
        load_cc(16'hFF00, 3'b100);
        load_cc(16'h0000, 3'b010);
        load_cc(16'h7FFF, 3'b001);
        bus_in = 16'h8000;
        tick();
        chk("nzp_hold_no_ld", {13'd0, nzp}, 16'h0001);

        // Multiplies
        run_mul(16'h0003, 16'h0007, 5'd0, 1'b0, 16'h0015, 1'b1, 1'b0);
        run_mul(16'h1234, 16'h0010, 5'd0, 1'b0, 16'h2340, 1'b0, 1'b1);
        run_mul(16'hFFFF, 16'h0002, 5'd0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_mul(16'h0003, 16'h0000, 5'b00111, 1'b1, 16'h0015, 1'b0, 1'b0);
        run_mul(16'hFFFD, 16'hFFF9, 5'd0, 1'b0, 16'h0015, 1'b0, 1'b0);

        // Reset mid-multiply at T8; nzp currently 100 from the ld_cc above
        aluk = 3'b100; sr1_in = 16'h0003; sr2_in = 16'h0007; sr2mux_sel = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < 8; t++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy_done", {14'd0, busy, done}, 16'h0000);
        chk("midrst_result", result, 16'h0000);
        chk("midrst_nzp", {13'd0, nzp}, 16'h0002);
        begin
            int seen = 0;
            for (int t = 0; t < 12; t++) begin
                if (done) seen++;
                tick();
            end
            chk("midrst_no_done", seen[15:0], 16'h0000);
        end
        aluk = 3'b000; sr1_in = 16'h0100; sr2_in = 16'h0023; start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_add_done", {15'd0, done}, 16'h0001);
        chk("post_rst_add", result, 16'h0123);

        // Reset overrides start and ld_cc in the same cycle
        rst_n = 1'b0; start = 1'b1; ld_cc = 1'b1; bus_in = 16'hFF00;
        aluk = 3'b011; sr1_in = 16'h5A5A;
        tick();
        rst_n = 1'b1; start = 1'b0; ld_cc = 1'b0;
        chk("rst_prio_done", {15'd0, done}, 16'h0000);
        chk("rst_prio_result", result, 16'h0000);
        chk("rst_prio_nzp", {13'd0, nzp}, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Execute stage fed directly by the eight-entry 16-bit register file. It consumes the two source-register read ports (SR1/SR2 outputs), and an optional sign-extended imm5. It performs an LC-3 ALU operation, extended with a multi-cycle multiply. It drives the result onto the global bus under a gate enable, and holds the NZP condition-code register, which loads from the global bus.

## Interface
- No parameters; all widths are fixed at 16 bits.
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request an operation; accepted only in IDLE.
- aluk  in  3  op: 000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 MUL, 101–111 treated as PASSA.
- sr1_in  in  16  operand A, from register file SR1 port.
- sr2_in  in  16  operand B, from register file SR2 port.
- imm5  in  5  immediate, two's complement.
- sr2mux_sel  in  1  1 = B is sign-extended imm5; 0 = B is sr2_in.
- gate_alu  in  1  1 = drive result onto alu_bus.
- bus_in  in  16  global bus value, for condition-code load.
- ld_cc  in  1  load NZP from bus_in at this edge.
- busy  out  1  high while a multiply is iterating.
- done  out  1  one-cycle pulse: result just updated.
- result  out  16  registered result; holds until the next completion.
- alu_bus  out  16  result when gate_alu=1, else 16'h0000; combinational, no tristate.
- nzp  out  3  condition codes {N,Z,P}.

## Operation
- **States:** IDLE, MUL.
- **Operand capture:** operands (A, and B after the sr2mux) are captured at the accepting edge. Later changes to sr1_in, sr2_in or imm5 have no effect on the operation in flight.
- **IDLE, start=1, aluk≠100:** result <= op(A,B) at that edge; done=1 for the next cycle; stay in IDLE.
  - ADD: A+B mod 2^16.
  - AND: bitwise A&B.
  - NOT: ~A.
  - PASSA: A.
- **IDLE, start=1, aluk=100:** load multiplicand=A, multiplier=B, acc=0, count=0; go to MUL.
- **MUL:** each cycle, perform one shift-add step:
  - if multiplier[0], acc += multiplicand (mod 2^16);
  - multiplicand <<= 1; multiplier >>= 1; count++.
  - After the 16th step: result <= acc, done pulse, go to IDLE.
- **Multiply arithmetic:** the result is the low 16 bits of the product. This is identical for signed and unsigned operands; overflow is silently discarded.
- **start while busy:** ignored; not queued.
- **NZP register:**
  - Independent of the state machine.
  - When ld_cc=1: N=bus_in[15]; Z=(bus_in==0); P=otherwise. Exactly one bit is set.
  - ld_cc is honoured in any state, including during a multiply.
- **Reset (rst_n=0 at posedge):**
  - state=IDLE, busy=0, done=0, result=16'h0000, nzp=3'b010, count=0.
  - Reset overrides start and ld_cc in the same cycle.
  - Reset during MUL aborts the operation: no done pulse, result=0.

## Timing
- Let T0 be the cycle in which start is sampled high while in IDLE.
- **Single-cycle ops:** result is valid and done=1 in T1. A new start is accepted in T1, giving back-to-back throughput of one op per cycle.
- **MUL:**
  - busy=1 in T1..T16; steps execute at the edges ending T1..T16.
  - done=1 and the new result appear in T17, with busy=0 in T17.
  - A new start is accepted in T17.
- done is high for exactly one cycle per completed operation.
- alu_bus follows result and gate_alu combinationally, with zero latency from gate_alu.
- nzp updates on the edge at which ld_cc=1 is sampled and is visible in the next cycle.

## Test plan
- **Reset values:** assert rst_n=0 for 2 cycles → busy=0, done=0, result=0x0000, nzp=010, alu_bus=0x0000 for any gate_alu.
- **ADD with immediate:** sr1_in=0x0005, imm5=5'b11111, sr2mux_sel=1, aluk=000, start → T1: result=0x0004, done=1. T2: done=0, result still 0x0004.
- **Logic ops and gating:** NOT with sr1_in=0x00FF → result=0xFF00. Then gate_alu=1 → alu_bus=0xFF00; gate_alu=0 → alu_bus=0x0000.
- **Condition codes:**
  - ld_cc with bus_in=0xFF00 → nzp=100.
  - bus_in=0x0000 → nzp=010.
  - bus_in=0x7FFF → nzp=001.
- **Multiply:**
  - MUL 0x0003×0x0007 → busy in T1..T16, done only in T17, result=0x0015. A start pulsed at T5 is ignored.
  - MUL 0x1234×0x0010 → result=0x2340 (wrap).
  - MUL 0xFFFF×0x0002 → result=0xFFFE.
- **Reset mid-operation:** start MUL 0x0003×0x0007, assert rst_n=0 at T8 → busy=0 and result=0x0000 next cycle; done is never pulsed. A subsequent ADD completes normally.
